// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, forward selects and
// the multiplier FSM states.
package exec_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Select 11 falls back to the register file value.
  function automatic logic [31:0] forward_mux(input logic [1:0]  sel,
                                              input logic [31:0] rf,
                                              input logic [31:0] wb,
                                              input logic [31:0] mem);
    case (sel)
      FWD_W:   forward_mux = wb;
      FWD_M:   forward_mux = mem;
      default: forward_mux = rf;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_mul_seq.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle;
// produces the low 32 bits of a*b after 32/MUL_BITS BUSY cycles.
module mul_seq
  import exec_pkg::*;
#(
  parameter int MUL_BITS = 1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output mul_state_t  state
);

  localparam int N  = 32 / MUL_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  mul_state_t    state_next;
  logic [31:0]   mcand;
  logic [31:0]   mplier;
  logic [31:0]   acc;
  logic [31:0]   partial;
  logic [CW-1:0] cnt;

  always_comb begin
    partial = acc;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (cnt == CW'(N - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        BUSY: begin
          acc    <= partial;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == BUSY);
  assign done    = (state == DONE);
  assign product = acc;

endmodule

// File: rtl/execute_stage.sv
// EX stage with operand forwarding, ALU, branch condition, iterative MUL and
// the EX/MEM pipeline register.
module execute_stage
  import exec_pkg::*;
#(
  parameter int MUL_BITS = 1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] RFRD1E,
  input  logic [31:0] RFRD2E,
  input  logic [31:0] simmE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  rdE,
  input  logic        RFWEE,
  input  logic        MtoRFSelE,
  input  logic        DMWEE,
  input  logic        BranchE,
  input  logic        ALUInSelE,
  input  logic        RFDSelE,
  input  logic [3:0]  ALUSelE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        ZeroE,
  output logic        PCSrcE,
  output logic        StallE,
  output logic [31:0] ALUOutM,
  output logic [31:0] DMdinM,
  output logic [4:0]  rtdM,
  output logic        RFWEM,
  output logic        MtoRFSelM,
  output logic        DMWEM
);

  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic [31:0] product;
  logic [4:0]  write_reg;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  mul_state_t  mul_state;

  assign src_a     = forward_mux(ForwardAE, RFRD1E, ResultW, ALUOutM);
  assign fwd_b     = forward_mux(ForwardBE, RFRD2E, ResultW, ALUOutM);
  assign src_b     = ALUInSelE ? simmE : fwd_b;
  assign write_reg = RFDSelE ? rdE : rtE;

  // Start only from IDLE so a MUL held in ID/EX during DONE does not relaunch.
  assign mul_start = RSTn && (ALUSelE == ALU_MUL) && (mul_state == IDLE);
  assign StallE    = mul_start | mul_busy;

  mul_seq #(
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .start   (mul_start),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product),
    .state   (mul_state)
  );

  always_comb begin
    alu_result = '0;
    case (ALUSelE)
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_NOR:  alu_result = ~(src_a | src_b);
      ALU_SLTU: alu_result = {31'b0, (src_a < src_b)};
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_SLT:  alu_result = {31'b0, ($signed(src_a) < $signed(src_b))};
      ALU_MUL:  alu_result = mul_done ? product : '0;
      default:  alu_result = '0;
    endcase
  end

  assign ZeroE  = (alu_result == '0);
  assign PCSrcE = BranchE & ZeroE;

  // A stalled cycle hands MEM a bubble: every field cleared.
  always_ff @(posedge CLK) begin
    if (!RSTn || StallE) begin
      ALUOutM   <= '0;
      DMdinM    <= '0;
      rtdM      <= '0;
      RFWEM     <= 1'b0;
      MtoRFSelM <= 1'b0;
      DMWEM     <= 1'b0;
    end else begin
      ALUOutM   <= alu_result;
      DMdinM    <= fwd_b;
      rtdM      <= write_reg;
      RFWEM     <= RFWEE;
      MtoRFSelM <= MtoRFSelE;
      DMWEM     <= DMWEE;
    end
  end

endmodule
